// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes,
// Funct codes, ALU operations and the datapath mux select values.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11,
    S_JR        = 4'd12,
    S_JAL       = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_LUI   = 3'b100;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] MEMTOREG_ALU = 2'b00;
  localparam logic [1:0] MEMTOREG_MDR = 2'b01;
  localparam logic [1:0] MEMTOREG_PC  = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_REG   = 2'b01;
  localparam logic [1:0] SRCA_SHAMT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BROFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG    = 2'b11;

  typedef struct packed {
    logic       pcWrite;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       regWrite;
    logic [1:0] regDst;
    logic [1:0] memtoReg;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic       extOp;
    logic [2:0] aluOp;
    logic [1:0] pcSource;
    logic       instrDone;
  } ctrl_t;

  // R-type functions executed through R_EXEC; jr is routed separately.
  function automatic logic funct_supported(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) || (f == FN_OR) ||
           (f == FN_NOR) || (f == FN_SLL) || (f == FN_SRL);
  endfunction

endpackage

// File: rtl/multicycle_output_decoder.sv
// Combinational decode of the controller state (plus the few live inputs)
// into every datapath select and write enable.
module multicycle_output_decoder
  import mips_ctrl_pkg::*;
(
  input  state_t      state_i,
  input  logic [5:0]  opcode_i,
  input  logic [5:0]  funct_i,
  input  logic        zero_i,
  input  logic        memReady_i,
  output ctrl_t       ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.memRead  = 1'b1;
        ctrl_o.aluSrcA  = SRCA_PC;
        ctrl_o.aluSrcB  = SRCB_FOUR;
        ctrl_o.aluOp    = ALU_ADD;
        ctrl_o.pcSource = PCSRC_ALU;
        ctrl_o.irWrite  = memReady_i;
        ctrl_o.pcWrite  = memReady_i;
      end
      S_DECODE: begin
        ctrl_o.aluSrcA = SRCA_PC;
        ctrl_o.aluSrcB = SRCB_BROFF;
        ctrl_o.aluOp   = ALU_ADD;
      end
      S_MEM_ADDR: begin
        ctrl_o.aluSrcA = SRCA_REG;
        ctrl_o.aluSrcB = SRCB_IMM;
        ctrl_o.extOp   = 1'b1;
        ctrl_o.aluOp   = ALU_ADD;
      end
      S_MEM_READ: begin
        ctrl_o.iorD    = 1'b1;
        ctrl_o.memRead = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.regDst    = REGDST_RT;
        ctrl_o.memtoReg  = MEMTOREG_MDR;
        ctrl_o.regWrite  = 1'b1;
        ctrl_o.instrDone = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl_o.iorD      = 1'b1;
        ctrl_o.memWrite  = 1'b1;
        ctrl_o.instrDone = memReady_i;
      end
      S_R_EXEC: begin
        // Shifts take their first operand from the shamt field.
        ctrl_o.aluSrcA = ((funct_i == FN_SLL) || (funct_i == FN_SRL)) ? SRCA_SHAMT : SRCA_REG;
        ctrl_o.aluSrcB = SRCB_REG;
        ctrl_o.aluOp   = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl_o.regDst    = REGDST_RD;
        ctrl_o.memtoReg  = MEMTOREG_ALU;
        ctrl_o.regWrite  = 1'b1;
        ctrl_o.instrDone = 1'b1;
      end
      S_I_EXEC: begin
        ctrl_o.aluSrcA = SRCA_REG;
        ctrl_o.aluSrcB = SRCB_IMM;
        case (opcode_i)
          OP_ADDI: begin
            ctrl_o.aluOp = ALU_ADD;
            ctrl_o.extOp = 1'b1;
          end
          OP_ORI:  ctrl_o.aluOp = ALU_OR;
          OP_LUI:  ctrl_o.aluOp = ALU_LUI;
          default: ctrl_o.aluOp = ALU_ADD;
        endcase
      end
      S_I_WB: begin
        ctrl_o.regDst    = REGDST_RT;
        ctrl_o.memtoReg  = MEMTOREG_ALU;
        ctrl_o.regWrite  = 1'b1;
        ctrl_o.instrDone = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.aluSrcA   = SRCA_REG;
        ctrl_o.aluSrcB   = SRCB_REG;
        ctrl_o.aluOp     = ALU_SUB;
        ctrl_o.pcSource  = PCSRC_ALUOUT;
        ctrl_o.pcWrite   = ((opcode_i == OP_BEQ) && zero_i) || ((opcode_i == OP_BNE) && !zero_i);
        ctrl_o.instrDone = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pcSource  = PCSRC_JUMP;
        ctrl_o.pcWrite   = 1'b1;
        ctrl_o.instrDone = 1'b1;
      end
      S_JR: begin
        ctrl_o.pcSource  = PCSRC_REG;
        ctrl_o.pcWrite   = 1'b1;
        ctrl_o.instrDone = 1'b1;
      end
      S_JAL: begin
        // PC already holds PC+4 from FETCH, so it is the link value.
        ctrl_o.regDst    = REGDST_RA;
        ctrl_o.memtoReg  = MEMTOREG_PC;
        ctrl_o.regWrite  = 1'b1;
        ctrl_o.pcSource  = PCSRC_JUMP;
        ctrl_o.pcWrite   = 1'b1;
        ctrl_o.instrDone = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS controller: state register, next-state logic and the
// sticky illegal-instruction flag; output decode lives in a sub-module.
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ExtOp,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;
  ctrl_t  ctrl, ctrlOut;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH: if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        state_d = S_FETCH;
        case (Opcode)
          OP_LW, OP_SW:           state_d = S_MEM_ADDR;
          OP_RTYPE: begin
            if (Funct == FN_JR)              state_d = S_JR;
            else if (funct_supported(Funct)) state_d = S_R_EXEC;
            else                             illegal_d = 1'b1;
          end
          OP_BEQ, OP_BNE:         state_d = S_BRANCH;
          OP_J:                   state_d = S_JUMP;
          OP_JAL:                 state_d = S_JAL;
          OP_ADDI, OP_ORI, OP_LUI: state_d = S_I_EXEC;
          default:                illegal_d = 1'b1;
        endcase
      end
      S_MEM_ADDR:  state_d = (Opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_R_EXEC:    state_d = S_R_WB;
      S_I_EXEC:    state_d = S_I_WB;
      default:     state_d = S_FETCH;
    endcase
  end

  multicycle_output_decoder u_decoder (
    .state_i    (state_q),
    .opcode_i   (Opcode),
    .funct_i    (Funct),
    .zero_i     (Zero),
    .memReady_i (mem_ready),
    .ctrl_o     (ctrl)
  );

  // Reset silences every output at once so an abandoned access cannot write.
  assign ctrlOut    = reset ? '0 : ctrl;
  assign PCWrite    = ctrlOut.pcWrite;
  assign IorD       = ctrlOut.iorD;
  assign MemRead    = ctrlOut.memRead;
  assign MemWrite   = ctrlOut.memWrite;
  assign IRWrite    = ctrlOut.irWrite;
  assign RegWrite   = ctrlOut.regWrite;
  assign RegDst     = ctrlOut.regDst;
  assign MemtoReg   = ctrlOut.memtoReg;
  assign ALUSrcA    = ctrlOut.aluSrcA;
  assign ALUSrcB    = ctrlOut.aluSrcB;
  assign ExtOp      = ctrlOut.extOp;
  assign ALUOp      = ctrlOut.aluOp;
  assign PCSource   = ctrlOut.pcSource;
  assign instr_done = ctrlOut.instrDone;
  assign illegal    = reset ? 1'b0 : illegal_q;
  assign state      = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed vector table, reset
// corner cases, then random instructions against an instruction-level model.
module tb_multicycle_control;

  logic       clk, reset, Zero, mem_ready;
  logic [5:0] Opcode, Funct;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, ExtOp, instr_done, illegal;
  logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  logic [3:0] state;

  typedef struct packed {
    logic [3:0] st;
    logic pcw, iord, mrd, mwr, irw, rw;
    logic [1:0] rdst, m2r, sa, sb;
    logic ext;
    logic [2:0] aop;
    logic [1:0] pcs;
    logic done;
  } out_t;

  typedef struct packed {
    out_t exp;
    logic mr, z, ill;
    logic [5:0] op, fn;
  } step_t;

  typedef struct {
    string name;
    logic [5:0] op, fn;
    logic z;
    int fw, mw, cycles;
    logic legal;
  } vec_t;

  out_t  obs;
  step_t q[$];
  vec_t  vecs[$];
  logic  modelIllegal;
  int    numChecks, numFails;

  assign obs = {state, PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite,
                RegDst, MemtoReg, ALUSrcA, ALUSrcB, ExtOp, ALUOp, PCSource, instr_done};

  multicycle_control dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtOp(ExtOp),
    .ALUOp(ALUOp), .PCSource(PCSource), .instr_done(instr_done),
    .illegal(illegal), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic isLegal(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h00, 6'h02, 6'h08};
    return op inside {6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h08, 6'h0D, 6'h0F};
  endfunction

  // Cycles per instruction with no wait states.
  function automatic int baseCycles(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h23) return 5;
    if (op == 6'h00 && fn == 6'h08) return 3;
    if (op inside {6'h04, 6'h05, 6'h02, 6'h03}) return 3;
    return 4;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    numChecks++;
    if (act !== exp) begin
      numFails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pushStep(input out_t o, input logic mr, input logic z,
                          input logic [5:0] op, input logic [5:0] fn);
    step_t s;
    s.exp = o; s.mr = mr; s.z = z; s.ill = modelIllegal; s.op = op; s.fn = fn;
    q.push_back(s);
  endtask

  // Expands one instruction into its expected cycle-by-cycle control trace.
  task automatic buildInstr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int fw, input int mw);
    out_t o;
    for (int w = 0; w < fw; w++) begin
      o = '0; o.st = 4'd0; o.mrd = 1; o.sb = 2'b01;
      pushStep(o, 1'b0, rnd(), op, fn);
    end
    o = '0; o.st = 4'd0; o.mrd = 1; o.sb = 2'b01; o.pcw = 1; o.irw = 1;
    pushStep(o, 1'b1, rnd(), op, fn);
    o = '0; o.st = 4'd1; o.sb = 2'b11;
    pushStep(o, rnd(), rnd(), op, fn);
    if (!isLegal(op, fn)) begin
      modelIllegal = 1'b1;
      return;
    end
    if (op == 6'h23 || op == 6'h2B) begin
      o = '0; o.st = 4'd2; o.sa = 2'b01; o.sb = 2'b10; o.ext = 1;
      pushStep(o, rnd(), rnd(), op, fn);
      if (op == 6'h23) begin
        o = '0; o.st = 4'd3; o.iord = 1; o.mrd = 1;
        for (int w = 0; w < mw; w++) pushStep(o, 1'b0, rnd(), op, fn);
        pushStep(o, 1'b1, rnd(), op, fn);
        o = '0; o.st = 4'd4; o.rw = 1; o.m2r = 2'b01; o.done = 1;
        pushStep(o, rnd(), rnd(), op, fn);
      end else begin
        o = '0; o.st = 4'd5; o.iord = 1; o.mwr = 1;
        for (int w = 0; w < mw; w++) pushStep(o, 1'b0, rnd(), op, fn);
        o.done = 1;
        pushStep(o, 1'b1, rnd(), op, fn);
      end
    end else if (op == 6'h00 && fn == 6'h08) begin
      o = '0; o.st = 4'd12; o.pcw = 1; o.pcs = 2'b11; o.done = 1;
      pushStep(o, rnd(), rnd(), op, fn);
    end else if (op == 6'h00) begin
      o = '0; o.st = 4'd6; o.sa = (fn == 6'h00 || fn == 6'h02) ? 2'b10 : 2'b01; o.aop = 3'b010;
      pushStep(o, rnd(), rnd(), op, fn);
      o = '0; o.st = 4'd7; o.rw = 1; o.rdst = 2'b01; o.done = 1;
      pushStep(o, rnd(), rnd(), op, fn);
    end else if (op == 6'h04 || op == 6'h05) begin
      o = '0; o.st = 4'd8; o.sa = 2'b01; o.aop = 3'b001; o.pcs = 2'b01; o.done = 1;
      o.pcw = (op == 6'h04) ? z : !z;
      pushStep(o, rnd(), z, op, fn);
    end else if (op == 6'h02) begin
      o = '0; o.st = 4'd9; o.pcw = 1; o.pcs = 2'b10; o.done = 1;
      pushStep(o, rnd(), rnd(), op, fn);
    end else if (op == 6'h03) begin
      o = '0; o.st = 4'd13; o.pcw = 1; o.rw = 1; o.rdst = 2'b10; o.m2r = 2'b10;
      o.pcs = 2'b10; o.done = 1;
      pushStep(o, rnd(), rnd(), op, fn);
    end else begin
      o = '0; o.st = 4'd10; o.sa = 2'b01; o.sb = 2'b10;
      o.ext = (op == 6'h08);
      o.aop = (op == 6'h08) ? 3'b000 : (op == 6'h0D) ? 3'b011 : 3'b100;
      pushStep(o, rnd(), rnd(), op, fn);
      o = '0; o.st = 4'd11; o.rw = 1; o.done = 1;
      pushStep(o, rnd(), rnd(), op, fn);
    end
  endtask

  task automatic applyStimulus(input step_t s);
    @(negedge clk);
    reset     = 1'b0;
    Opcode    = s.op;
    Funct     = s.fn;
    mem_ready = s.mr;
    Zero      = s.z;
  endtask

  task automatic runTrace(input string name, output int doneCycle, output int doneCount);
    doneCycle = 0;
    doneCount = 0;
    for (int i = 0; i < q.size(); i++) begin
      applyStimulus(q[i]);
      #1;
      checkOutput({name, "_ctrl"}, 32'(obs), 32'(q[i].exp));
      checkOutput({name, "_illegal"}, 32'(illegal), 32'(q[i].ill));
      if (instr_done) begin
        doneCount++;
        if (doneCycle == 0) doneCycle = i + 1;
      end
    end
    q.delete();
  endtask

  task automatic runInstr(input string name, input logic [5:0] op, input logic [5:0] fn,
                          input logic z, input int fw, input int mw,
                          input int expCycles, input logic expLegal);
    int dc, dn;
    buildInstr(op, fn, z, fw, mw);
    runTrace(name, dc, dn);
    checkOutput({name, "_done_count"}, 32'(dn), expLegal ? 32'd1 : 32'd0);
    if (expLegal) checkOutput({name, "_cycles"}, 32'(dc), 32'(expCycles));
  endtask

  task automatic doReset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      reset = 1'b1;
      mem_ready = 1'b1;
      #1;
      checkOutput("reset_outputs", 32'(obs), 32'd0);
      checkOutput("reset_illegal", 32'(illegal), 32'd0);
    end
    modelIllegal = 1'b0;
  endtask

  initial begin
    int dc, dn;
    logic [5:0] opList[12] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02,
                               6'h03, 6'h08, 6'h0D, 6'h0F, 6'h00, 6'h3F};
    logic [5:0] fnList[9]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h00, 6'h02, 6'h08, 6'h3F};

    numChecks = 0; numFails = 0; modelIllegal = 1'b0;
    reset = 1'b1; mem_ready = 1'b1; Zero = 1'b0; Opcode = 6'h00; Funct = 6'h20;

    vecs.push_back('{"add",       6'h00, 6'h20, 1'b0, 0, 0, 4, 1'b1});
    vecs.push_back('{"add_fwait", 6'h00, 6'h22, 1'b0, 1, 0, 5, 1'b1});
    vecs.push_back('{"lw_wait2",  6'h23, 6'h00, 1'b0, 0, 2, 7, 1'b1});
    vecs.push_back('{"lw",        6'h23, 6'h11, 1'b1, 0, 0, 5, 1'b1});
    vecs.push_back('{"sw_wait1",  6'h2B, 6'h00, 1'b0, 0, 1, 5, 1'b1});
    vecs.push_back('{"beq_taken", 6'h04, 6'h00, 1'b1, 0, 0, 3, 1'b1});
    vecs.push_back('{"beq_not",   6'h04, 6'h00, 1'b0, 0, 0, 3, 1'b1});
    vecs.push_back('{"bne_not",   6'h05, 6'h00, 1'b1, 0, 0, 3, 1'b1});
    vecs.push_back('{"bne_taken", 6'h05, 6'h00, 1'b0, 0, 0, 3, 1'b1});
    vecs.push_back('{"j",         6'h02, 6'h00, 1'b0, 0, 0, 3, 1'b1});
    vecs.push_back('{"jal",       6'h03, 6'h00, 1'b0, 0, 0, 3, 1'b1});
    vecs.push_back('{"jr",        6'h00, 6'h08, 1'b0, 0, 0, 3, 1'b1});
    vecs.push_back('{"sll",       6'h00, 6'h00, 1'b0, 0, 0, 4, 1'b1});
    vecs.push_back('{"srl",       6'h00, 6'h02, 1'b0, 0, 0, 4, 1'b1});
    vecs.push_back('{"nor",       6'h00, 6'h27, 1'b0, 0, 0, 4, 1'b1});
    vecs.push_back('{"addi",      6'h08, 6'h00, 1'b0, 0, 0, 4, 1'b1});
    vecs.push_back('{"ori",       6'h0D, 6'h00, 1'b0, 0, 0, 4, 1'b1});
    vecs.push_back('{"lui",       6'h0F, 6'h00, 1'b0, 0, 0, 4, 1'b1});
    vecs.push_back('{"bad_funct", 6'h00, 6'h01, 1'b0, 0, 0, 2, 1'b0});
    vecs.push_back('{"bad_op",    6'h3F, 6'h20, 1'b0, 0, 0, 2, 1'b0});

    doReset(2);
    foreach (vecs[i])
      runInstr(vecs[i].name, vecs[i].op, vecs[i].fn, vecs[i].z,
               vecs[i].fw, vecs[i].mw, vecs[i].cycles, vecs[i].legal);

    // Illegal flag must stay set in the following FETCH wait cycle.
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    checkOutput("illegal_sticky", 32'(illegal), 32'd1);
    checkOutput("illegal_back_to_fetch", 32'(state), 32'd0);

    // Reset landing in MEM_WRITE must suppress the store.
    buildInstr(6'h2B, 6'h00, 1'b0, 0, 0);
    while (q.size() > 3) void'(q.pop_back());
    runTrace("sw_pre_reset", dc, dn);
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b1;
    #1;
    checkOutput("reset_in_memwrite_MemWrite", 32'(MemWrite), 32'd0);
    checkOutput("reset_in_memwrite_outputs", 32'(obs), 32'd0);
    modelIllegal = 1'b0;

    for (int n = 0; n < 60; n++) begin
      logic [5:0] op, fn;
      int fw, mw;
      op = opList[$urandom_range(0, 11)];
      fn = (op == 6'h00) ? fnList[$urandom_range(0, 8)] : 6'($urandom_range(0, 63));
      fw = $urandom_range(0, 2);
      mw = $urandom_range(0, 2);
      runInstr("rand", op, fn, rnd(), fw, mw,
               baseCycles(op, fn) + fw + ((op == 6'h23 || op == 6'h2B) ? mw : 0),
               isLegal(op, fn));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
